// File: rtl/life_gen_sequencer.sv
// Frame-level scheduler and cell-walk sequencer for the 8x8 Life engine.
// Picks load / generation per frame tick and strobes the datapath one cell per beat.
module life_gen_sequencer #(
    parameter int CELL_BITS  = 6,
    parameter int SPEED_BITS = 3,
    parameter int GEN_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  run,
    input  logic                  step,
    input  logic                  load_req,
    input  logic [SPEED_BITS-1:0] speed,
    input  logic                  cell_ready,
    output logic [CELL_BITS-1:0]  cell_idx,
    output logic                  copy_en,
    output logic                  compute_en,
    output logic                  load_en,
    output logic                  disp_sel,
    output logic                  busy,
    output logic                  gen_done,
    output logic [GEN_BITS-1:0]   gen_count,
    output logic [1:0]            bg_phase
);

    typedef enum logic [2:0] {IDLE, LOAD, COPY, COMPUTE, DONE} state_t;

    state_t                state, state_nx;
    logic                  vsync_q, step_q, load_q;
    logic                  frame_tick, step_edge, load_edge;
    logic [SPEED_BITS-1:0] frame_cnt;
    logic                  gen_pend, load_pend;
    logic                  sched_hit, gen_any, load_any, accept;
    logic                  beat, last_beat;

    assign frame_tick = vsync & ~vsync_q;
    assign step_edge  = step & ~step_q;
    assign load_edge  = load_req & ~load_q;

    // Requests raised on the same tick that IDLE samples are honoured immediately.
    assign sched_hit = frame_tick & run & (frame_cnt == speed);
    assign gen_any   = gen_pend | sched_hit | (step_edge & ~run);
    assign load_any  = load_pend | load_edge;
    assign accept    = (state == IDLE) & frame_tick & (gen_any | load_any);

    assign beat      = (copy_en | compute_en | load_en) & cell_ready;
    assign last_beat = beat & (cell_idx == '1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            step_q    <= 1'b0;
            load_q    <= 1'b0;
            frame_cnt <= '0;
            gen_pend  <= 1'b0;
            load_pend <= 1'b0;
            cell_idx  <= '0;
            gen_count <= '0;
            bg_phase  <= '0;
            state     <= IDLE;
        end else begin
            vsync_q <= vsync;
            step_q  <= step;
            load_q  <= load_req;
            if (frame_tick)
                frame_cnt <= (run && frame_cnt != speed) ? frame_cnt + 1'b1 : '0;
            // Accepting either request drops any coalesced generation request.
            gen_pend  <= accept ? 1'b0 : gen_any;
            load_pend <= accept ? 1'b0 : load_any;
            if (beat)
                cell_idx <= cell_idx + 1'b1;
            if (state == DONE) begin
                gen_count <= gen_count + 1'b1;
                bg_phase  <= bg_phase + 1'b1;
            end else if (state == LOAD && last_beat) begin
                gen_count <= '0;
                bg_phase  <= '0;
            end
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        copy_en    = 1'b0;
        compute_en = 1'b0;
        load_en    = 1'b0;
        disp_sel   = 1'b0;
        gen_done   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nx = load_any ? LOAD : COPY;
            LOAD: begin
                load_en = 1'b1;
                if (last_beat) state_nx = IDLE;
            end
            COPY: begin
                copy_en = 1'b1;
                if (last_beat) state_nx = COMPUTE;
            end
            COMPUTE: begin
                // Show prev while curr is being rewritten.
                compute_en = 1'b1;
                disp_sel   = 1'b1;
                if (last_beat) state_nx = DONE;
            end
            DONE: begin
                gen_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: directed scenarios plus randomized run/speed/ready
// rounds, checked against a frame-count / beat-count model of the scheduler.
module tb_life_gen_sequencer;

    localparam int CB = 6;
    localparam int SB = 3;
    localparam int GB = 16;
    localparam int NC = 1 << CB;

    logic          clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, run = 1'b0;
    logic          step = 1'b0, load_req = 1'b0, cell_ready = 1'b1;
    logic [SB-1:0] speed = '0;
    logic [CB-1:0] cell_idx;
    logic          copy_en, compute_en, load_en, disp_sel, busy, gen_done;
    logic [GB-1:0] gen_count;
    logic [1:0]    bg_phase;

    int checks = 0, errors = 0;

    life_gen_sequencer #(.CELL_BITS(CB), .SPEED_BITS(SB), .GEN_BITS(GB)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .run(run), .step(step),
        .load_req(load_req), .speed(speed), .cell_ready(cell_ready),
        .cell_idx(cell_idx), .copy_en(copy_en), .compute_en(compute_en),
        .load_en(load_en), .disp_sel(disp_sel), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count), .bg_phase(bg_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference bookkeeping: edges, beats and cycles per generation.
    int   cyc = 0, tick_cyc = 0;
    logic vs_q = 1'b0;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        vs_q <= vsync;
        if (vsync && !vs_q) tick_cyc <= cyc;
    end

    int   cexp = 0, pexp = 0, lexp = 0;
    int   copy_beats = 0, comp_beats = 0, load_beats = 0, copy_cyc = 0, comp_cyc = 0;
    int   gens = 0, loads_done = 0, last_copy_cyc = 0, last_comp_cyc = 0, last_lat = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cexp = 0; pexp = 0; lexp = 0;
            copy_beats = 0; comp_beats = 0; load_beats = 0;
            copy_cyc = 0; comp_cyc = 0; prev_done = 1'b0;
        end else begin
            chk("onehot_en", 32'(($countones({copy_en, compute_en, load_en}) <= 1)), 1);
            chk("disp_sel", 32'(disp_sel), 32'(compute_en));
            chk("busy", 32'(busy), 32'(copy_en | compute_en | load_en | gen_done));
            if (copy_en) copy_cyc++;
            if (compute_en) comp_cyc++;
            if (copy_en && cell_ready) begin
                chk("copy_idx", 32'(cell_idx), cexp);
                cexp = (cexp + 1) % NC; copy_beats++;
            end
            if (compute_en && cell_ready) begin
                chk("comp_idx", 32'(cell_idx), pexp);
                pexp = (pexp + 1) % NC; comp_beats++;
            end
            if (load_en && cell_ready) begin
                chk("load_idx", 32'(cell_idx), lexp);
                lexp = (lexp + 1) % NC; load_beats++;
                if (load_beats == NC) begin loads_done++; load_beats = 0; end
            end
            if (gen_done) begin
                chk("done_width", 32'(prev_done), 0);
                chk("copy_beats", copy_beats, NC);
                chk("comp_beats", comp_beats, NC);
                gens++;
                last_copy_cyc = copy_cyc; last_comp_cyc = comp_cyc;
                last_lat = cyc - tick_cyc;
                copy_beats = 0; comp_beats = 0; copy_cyc = 0; comp_cyc = 0;
            end
            prev_done = gen_done;
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) if (rand_ready) #1 cell_ready = ($urandom % 4) != 0;

    task automatic frame(input int gap);
        @(posedge clk); #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic pulse_load();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 copy, 1 compute, 2 load; returns at the negedge where it is seen.
    task automatic wait_for(input int which, input int idx, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = copy_en    && int'(cell_idx) == idx;
                1:       hit = compute_en && int'(cell_idx) == idx;
                default: hit = load_en    && int'(cell_idx) == idx;
            endcase
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_idx"},   32'(cell_idx), 0);
        chk({tag, "_copy"},  32'(copy_en), 0);
        chk({tag, "_comp"},  32'(compute_en), 0);
        chk({tag, "_load"},  32'(load_en), 0);
        chk({tag, "_disp"},  32'(disp_sel), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(gen_done), 0);
        chk({tag, "_gcnt"},  32'(gen_count), 0);
        chk({tag, "_bg"},    32'(bg_phase), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, l0, s, n, e, gm;

        repeat (3) @(negedge clk);
        check_reset("reset");
        @(negedge clk); rst_n = 1'b1;

        // run=0: frames alone never start anything
        repeat (3) frame(20);
        check_reset("idle3");
        chk("idle3_gens", gens, 0);

        // single generation, run dropped right after the tick
        speed = 0; run = 1'b1;
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0; run = 1'b0;
        idle_wait(200);
        chk("g1_gens", gens, 1);
        chk("g1_copy_cyc", last_copy_cyc, 64);
        chk("g1_comp_cyc", last_comp_cyc, 64);
        chk("g1_latency", last_lat, 129);
        chk("g1_gcnt", 32'(gen_count), 1);
        chk("g1_bg", 32'(bg_phase), 1);
        chk("g1_busy", 32'(busy), 0);

        // speed=2: one generation every third frame
        g0 = gens; speed = 2; run = 1'b1;
        repeat (9) frame(200);
        run = 1'b0; frame(20);
        chk("spd2_gens", gens - g0, 3);
        chk("spd2_gcnt", 32'(gen_count), 4);
        chk("spd2_bg", 32'(bg_phase), 0);

        // step while stopped: exactly one generation over two frames
        g0 = gens;
        pulse_step();
        repeat (2) frame(200);
        chk("step_gens", gens - g0, 1);
        chk("step_gcnt", 32'(gen_count), 5);

        // step while running is ignored
        g0 = gens; speed = 7; run = 1'b1;
        pulse_step();
        frame(200);
        run = 1'b0; frame(200);
        chk("step_run_gens", gens - g0, 0);
        chk("step_run_gcnt", 32'(gen_count), 5);

        // stall 5 cycles at copy index 10
        pulse_step(); vs_pulse();
        wait_for(0, 9, "stall");
        @(posedge clk); #1 cell_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_idx", 32'(cell_idx), 10);
            chk("stall_copy", 32'(copy_en), 1);
        end
        @(posedge clk); #1 cell_ready = 1'b1;
        idle_wait(200);
        chk("stall_copy_cyc", last_copy_cyc, 69);
        chk("stall_comp_cyc", last_comp_cyc, 64);
        chk("stall_gcnt", 32'(gen_count), 6);

        // load waits for a frame tick, then clears counters
        l0 = loads_done;
        pulse_load();
        idle_wait(20);
        chk("load_wait_busy", 32'(busy), 0);
        frame(200);
        chk("load_done", loads_done - l0, 1);
        chk("load_gcnt", 32'(gen_count), 0);
        chk("load_bg", 32'(bg_phase), 0);

        speed = 0; run = 1'b1;
        repeat (7) frame(200);
        run = 1'b0; frame(20);
        chk("g7_gcnt", 32'(gen_count), 7);
        chk("g7_bg", 32'(bg_phase), 3);

        // load request mid-compute: generation finishes first
        l0 = loads_done;
        pulse_step(); vs_pulse();
        wait_for(1, 20, "midload");
        pulse_load();
        idle_wait(200);
        chk("midload_gcnt", 32'(gen_count), 8);
        chk("midload_nostart", loads_done - l0, 0);
        chk("midload_busy", 32'(busy), 0);
        frame(200);
        chk("midload_done", loads_done - l0, 1);
        chk("midload_gcnt0", 32'(gen_count), 0);
        chk("midload_bg0", 32'(bg_phase), 0);

        // reset in the middle of a load
        l0 = loads_done;
        pulse_load(); vs_pulse();
        wait_for(2, 30, "rstload");
        rst_n = 1'b0;
        #1 check_reset("rstload");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame(100);
        chk("rstload_busy", 32'(busy), 0);
        chk("rstload_loads", loads_done - l0, 0);

        // randomized rounds with random ready stalls
        gm = 0; rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            s = int'($urandom_range(0, 3));
            n = int'($urandom_range(4, 10));
            speed = SB'(s); g0 = gens; run = 1'b1;
            repeat (n) frame(600);
            run = 1'b0; frame(20);
            e = n / (s + 1);
            gm += e;
            chk("rand_gens", gens - g0, e);
            chk("rand_gcnt", 32'(gen_count), gm);
            chk("rand_bg", 32'(bg_phase), gm % 4);
        end
        rand_ready = 1'b0;
        #2 cell_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
